// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: owns the fetch PC, sequences a fixed-latency IM read and fills the IF/ID slot.
// Optional IF_ADDR_CHECK_EN flags misaligned or out-of-range fetches as AdEL in if_exc.
module im_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
  parameter logic [31:0] TEXT_START  = 32'h0000_3000,
  parameter int unsigned IM_BYTES    = 16384,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        br_req,
  input  logic [31:0] br_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_code,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc
);

  localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 7 || IM_BYTES < 4 || TEXT_START[1:0] != 2'b00) begin : g_bad_cfg
    $error("im_fetch_ctrl: illegal parameter configuration");
  end

  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_exc_q, if_exc_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_done;
  logic        capture;
  logic        fetch_fault;
  logic [31:0] fetch_word;

  always_comb begin
    redirect    = 1'b1;
    redirect_pc = HANDLER_PC;
    if (exc_req) begin
      redirect_pc = HANDLER_PC;
    end else if (eret_req) begin
      redirect_pc = epc;
    end else if (br_req) begin
      redirect_pc = br_target;
    end else begin
      redirect = 1'b0;
    end
  end

`ifdef IF_ADDR_CHECK_EN
  // 33-bit compare so a text segment ending at 4 GiB does not wrap.
  localparam logic [32:0] TEXT_END = {1'b0, TEXT_START} + 33'(IM_BYTES);

  always_comb begin
    fetch_fault = (pc_q[1:0] != 2'b00)
                || ({1'b0, pc_q} < {1'b0, TEXT_START})
                || ({1'b0, pc_q} >= TEXT_END);
    fetch_word  = fetch_fault ? 32'h0 : im_code;
  end
`else
  assign fetch_fault = 1'b0;
  assign fetch_word  = im_code;
`endif

  assign fetch_done = (cnt_q == LAST_CNT);
  assign capture    = fetch_done && (!if_valid_q || !stall);

  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_exc_d   = if_exc_q;
    if (redirect) begin
      pc_d       = redirect_pc;
      cnt_d      = 3'd0;
      if_valid_d = 1'b0;
    end else if (capture) begin
      if_instr_d = fetch_word;
      if_pc_d    = pc_q;
      if_exc_d   = fetch_fault;
      if_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
      cnt_d      = 3'd0;
    end else begin
      // A blocked completion leaves cnt and pc alone so im_code stays valid.
      if (!fetch_done) begin
        cnt_d = cnt_q + 3'd1;
      end
      if (if_valid_q && !stall) begin
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      if_exc_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_exc_q   <= if_exc_d;
    end
  end

  assign im_addr  = pc_q;
  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_exc   = if_exc_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Testbench for im_fetch_ctrl: one instance at MEM_LATENCY=1 and one at MEM_LATENCY=3,
// each fed by an IM model whose data is only valid once the address has been stable long enough.
module tb_im_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, reset3;
  logic        stall, exc_req, eret_req, br_req;
  logic [31:0] epc, br_target;

  logic [31:0] im_addr1, im_code1, if_pc1, if_instr1;
  logic        if_valid1, if_exc1;
  logic [31:0] im_addr3, im_code3, if_pc3, if_instr3;
  logic        if_valid3, if_exc3;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_item_t;

  exp_item_t q1[$];
  exp_item_t q3[$];
  exp_item_t e1, e3;

  int          age1 = 0, age3 = 0;
  logic [31:0] last1, last3;

  im_fetch_ctrl #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .br_req(br_req), .br_target(br_target), .im_addr(im_addr1), .im_code(im_code1),
    .if_valid(if_valid1), .if_pc(if_pc1), .if_instr(if_instr1), .if_exc(if_exc1)
  );

  im_fetch_ctrl #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .br_req(br_req), .br_target(br_target), .im_addr(im_addr3), .im_code(im_code3),
    .if_valid(if_valid3), .if_pc(if_pc3), .if_instr(if_instr3), .if_exc(if_exc3)
  );

  // Program image: word at 0x3000 is 0x24010001, 0x3004 is 0x24020002, and so on.
  function automatic logic [31:0] code_of(input logic [31:0] a);
    logic [31:0] d;
    logic [15:0] idx;
    d   = a - 32'h0000_3000;
    idx = d[17:2] + 16'd1;
    return 32'h2400_0000 | {idx, idx};
  endfunction

  // IM models: age counts negedges the address has been held; data is garbage until age >= latency.
  always @(negedge clk) begin
    if (im_addr1 === last1) age1 <= (age1 < 15) ? age1 + 1 : age1;
    else age1 <= 1;
    last1 <= im_addr1;
    if (im_addr3 === last3) age3 <= (age3 < 15) ? age3 + 1 : age3;
    else age3 <= 1;
    last3 <= im_addr3;
  end

  assign im_code1 = (age1 >= 1) ? code_of(im_addr1) : 32'hDEAD_BEEF;
  assign im_code3 = (age3 >= 3) ? code_of(im_addr3) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic e, input logic r, input logic [31:0] ep,
                               input logic b, input logic [31:0] t);
    stall     = s;
    exc_req   = e;
    eret_req  = r;
    epc       = ep;
    br_req    = b;
    br_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic push1(input logic [31:0] pc);
    exp_item_t it;
    it.pc = pc; it.instr = code_of(pc); it.exc = 1'b0;
    q1.push_back(it);
  endtask

  task automatic push3(input logic [31:0] pc);
    exp_item_t it;
    it.pc = pc; it.instr = code_of(pc); it.exc = 1'b0;
    q3.push_back(it);
  endtask

  // Monitors: an instruction is delivered when the slot is valid and not stalled.
  always @(negedge clk) begin
    if (!reset1 && if_valid1 && !stall) begin
      if (q1.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL dut1_extra_delivery: got if_pc %h, expected no delivery", if_pc1);
      end else begin
        e1 = q1.pop_front();
        checkOutput("dut1_if_pc", if_pc1, e1.pc);
        checkOutput("dut1_if_instr", if_instr1, e1.instr);
        checkOutput("dut1_if_exc", 32'(if_exc1), 32'(e1.exc));
      end
    end
    if (!reset3 && if_valid3 && !stall) begin
      if (q3.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL dut3_extra_delivery: got if_pc %h, expected no delivery", if_pc3);
      end else begin
        e3 = q3.pop_front();
        checkOutput("dut3_if_pc", if_pc3, e3.pc);
        checkOutput("dut3_if_instr", if_instr3, e3.instr);
        checkOutput("dut3_if_exc", 32'(if_exc3), 32'(e3.exc));
      end
    end
  end

  // Address-check targets and whether each one should fault when checking is enabled.
  logic [31:0] addr_tgt [5] = '{32'h0000_3002, 32'h0000_2FFC, 32'h0000_3004, 32'h0000_6FFC, 32'h0000_7000};
  logic        addr_bad [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic        exp_exc;
    logic [31:0] exp_instr;
    reset1 = 1'b1; reset3 = 1'b1;
    stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0; br_req = 1'b0; epc = 32'h0; br_target = 32'h0;
    idle_cycles(3);

    checkOutput("rst_if_valid", 32'(if_valid1), 32'd0);
    checkOutput("rst_if_pc", if_pc1, 32'h0);
    checkOutput("rst_if_instr", if_instr1, 32'h0);
    checkOutput("rst_if_exc", 32'(if_exc1), 32'd0);
    checkOutput("rst_im_addr", im_addr1, 32'h0000_3000);

    // Free run at latency 1, then a 3-cycle stall on the 0x3008 slot.
    push1(32'h3000); push1(32'h3004); push1(32'h3008); push1(32'h300C); push1(32'h3010);
    reset1 = 1'b0;
    idle_cycles(1);
    checkOutput("first_valid", 32'(if_valid1), 32'd1);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_valid", 32'(if_valid1), 32'd1);
      checkOutput("stall_if_pc", if_pc1, 32'h0000_3008);
      checkOutput("stall_if_instr", if_instr1, 32'h2403_0003);
      checkOutput("stall_im_addr", im_addr1, 32'h0000_300C);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    idle_cycles(2);

    // All three redirects at once: exception entry wins.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3010, 1'b1, 32'h3100);
    checkOutput("exc_im_addr", im_addr1, 32'h0000_4180);
    checkOutput("exc_flush", 32'(if_valid1), 32'd0);
    push1(32'h4180);
    idle_cycles(1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3010, 1'b1, 32'h3100);
    checkOutput("eret_im_addr", im_addr1, 32'h0000_3010);
    checkOutput("eret_flush", 32'(if_valid1), 32'd0);
    push1(32'h3010);
    idle_cycles(1);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3100);
    checkOutput("br_im_addr", im_addr1, 32'h0000_3100);
    checkOutput("br_flush", 32'(if_valid1), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("br_fill_valid", 32'(if_valid1), 32'd1);
    checkOutput("br_fill_pc", if_pc1, 32'h0000_3100);

    // Redirect while the slot is stalled still flushes it.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3200);
    checkOutput("stall_redirect_flush", 32'(if_valid1), 32'd0);
    checkOutput("stall_redirect_im_addr", im_addr1, 32'h0000_3200);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("stall_refill_valid", 32'(if_valid1), 32'd1);
    checkOutput("stall_refill_pc", if_pc1, 32'h0000_3200);

    for (int i = 0; i < 5; i++) begin
`ifdef IF_ADDR_CHECK_EN
      exp_exc   = addr_bad[i];
      exp_instr = addr_bad[i] ? 32'h0 : code_of(addr_tgt[i]);
`else
      exp_exc   = 1'b0;
      exp_instr = code_of(addr_tgt[i]);
`endif
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, addr_tgt[i]);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("addr_valid", 32'(if_valid1), 32'd1);
      checkOutput("addr_if_pc", if_pc1, addr_tgt[i]);
      checkOutput("addr_if_exc", 32'(if_exc1), 32'(exp_exc));
      checkOutput("addr_if_instr", if_instr1, exp_instr);
    end

    reset1 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5000);
    checkOutput("reset_beats_redirect", im_addr1, 32'h0000_3000);
    checkOutput("reset_slot_cleared", 32'(if_valid1), 32'd0);

    // Latency 3: one instruction every third cycle.
    push3(32'h3000); push3(32'h3004);
    reset3 = 1'b0;
    idle_cycles(1); checkOutput("l3_wait_a", 32'(if_valid3), 32'd0);
    idle_cycles(1); checkOutput("l3_wait_b", 32'(if_valid3), 32'd0);
    idle_cycles(1); checkOutput("l3_first", 32'(if_valid3), 32'd1);
    idle_cycles(1); checkOutput("l3_gap_a", 32'(if_valid3), 32'd0);
    idle_cycles(1); checkOutput("l3_gap_b", 32'(if_valid3), 32'd0);
    idle_cycles(1); checkOutput("l3_second", 32'(if_valid3), 32'd1);
    idle_cycles(1);

    // Branch with a fetch in flight.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3040);
    checkOutput("l3_br_im_addr", im_addr3, 32'h0000_3040);
    checkOutput("l3_br_low_a", 32'(if_valid3), 32'd0);
    push3(32'h3040);
    idle_cycles(1); checkOutput("l3_br_low_b", 32'(if_valid3), 32'd0);
    idle_cycles(1); checkOutput("l3_br_low_c", 32'(if_valid3), 32'd0);
    idle_cycles(1); checkOutput("l3_br_fill", 32'(if_valid3), 32'd1);

    // Completion blocked by stall: address and slot hold, capture follows release.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("l3_block_im_addr", im_addr3, 32'h0000_3044);
    checkOutput("l3_block_if_pc", if_pc3, 32'h0000_3040);
    checkOutput("l3_block_valid", 32'(if_valid3), 32'd1);
    push3(32'h3044);
    idle_cycles(1);
    checkOutput("l3_release_pc", if_pc3, 32'h0000_3044);
    idle_cycles(1);
    reset3 = 1'b1;
    idle_cycles(1);

    checkOutput("dut1_queue_empty", 32'(q1.size()), 32'd0);
    checkOutput("dut3_queue_empty", 32'(q3.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of stimulus, expected finish before time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
